// File: rtl/pc_branch_unit.sv
// Program-counter and branch-resolution stage: latched ALU flags, writable branch-target LUT,
// and a start/halt run controller. Optional taken-branch counter enabled by PC_BRANCH_COUNT_EN.
module pc_branch_unit #(
    parameter int PC_W     = 10,
    parameter int LUT_AW   = 4,
    parameter int START_PC = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              halt_req,
    input  logic              stall,
    input  logic              equalFlag,
    input  logic              lessThanFlag,
    input  logic              eq_we,
    input  logic              lt_we,
    input  logic              branch_en,
    input  logic [1:0]        branch_cond,
    input  logic [LUT_AW-1:0] target_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_addr,
    input  logic [PC_W-1:0]   lut_data,
    output logic [PC_W-1:0]   PC,
    output logic              eq_q,
    output logic              lt_q,
    output logic              taken,
    output logic              done
`ifdef PC_BRANCH_COUNT_EN
    ,
    output logic [15:0]       taken_cnt
`endif
);

    localparam int LUT_DEPTH = 2 ** LUT_AW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_lut [LUT_DEPTH];
    logic            w_condMet;
    logic            w_branchTaken;

    // Condition uses the flags as they stood before this edge, so a same-cycle flag write only affects later branches
    always_comb begin
        w_condMet = 1'b0;
        case (branch_cond)
            2'b00:   w_condMet = 1'b1;
            2'b01:   w_condMet = eq_q;
            2'b10:   w_condMet = lt_q;
            default: w_condMet = ~eq_q;
        endcase
        w_branchTaken = branch_en & w_condMet;
    end

`ifdef PC_BRANCH_COUNT_EN
    logic [15:0] r_takenCnt;
    assign taken_cnt = r_takenCnt;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            PC      <= PC_W'(START_PC);
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            taken   <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
`ifdef PC_BRANCH_COUNT_EN
            r_takenCnt <= '0;
`endif
        end else begin
            // The branch below reads r_lut before this write lands, giving old-entry semantics on a collision
            if (lut_we) begin
                r_lut[lut_addr] <= lut_data;
            end
            taken <= 1'b0;
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_state <= S_RUN;
                        PC      <= PC_W'(START_PC);
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        done    <= 1'b0;
`ifdef PC_BRANCH_COUNT_EN
                        r_takenCnt <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (eq_we) begin
                            eq_q <= equalFlag;
                        end
                        if (lt_we) begin
                            lt_q <= lessThanFlag;
                        end
                        if (halt_req) begin
                            r_state <= S_HALTED;
                            done    <= 1'b1;
                        end else if (w_branchTaken) begin
                            PC    <= r_lut[target_idx];
                            taken <= 1'b1;
`ifdef PC_BRANCH_COUNT_EN
                            if (r_takenCnt != 16'hFFFF) begin
                                r_takenCnt <= r_takenCnt + 16'd1;
                            end
`endif
                        end else begin
                            PC <= PC + PC_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: directed scenarios followed by random traffic,
// expected outputs come from a cycle-level behavioural model and are checked by a separate monitor.
module tb_pc_branch_unit;

    localparam int PC_W      = 10;
    localparam int LUT_AW    = 4;
    localparam int LUT_DEPTH = 16;
    localparam int START_PC  = 0;
    localparam int PC_MOD    = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              haltReq = 1'b0;
    logic              stall = 1'b0;
    logic              equalFlag = 1'b0;
    logic              lessThanFlag = 1'b0;
    logic              eqWe = 1'b0;
    logic              ltWe = 1'b0;
    logic              branchEn = 1'b0;
    logic [1:0]        branchCond = 2'b00;
    logic [LUT_AW-1:0] targetIdx = '0;
    logic              lutWe = 1'b0;
    logic [LUT_AW-1:0] lutAddr = '0;
    logic [PC_W-1:0]   lutData = '0;
    logic [PC_W-1:0]   pc;
    logic              eqQ;
    logic              ltQ;
    logic              taken;
    logic              done;
`ifdef PC_BRANCH_COUNT_EN
    logic [15:0]       takenCnt;
`endif

    pc_branch_unit #(
        .PC_W    (PC_W),
        .LUT_AW  (LUT_AW),
        .START_PC(START_PC)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .start       (start),
        .halt_req    (haltReq),
        .stall       (stall),
        .equalFlag   (equalFlag),
        .lessThanFlag(lessThanFlag),
        .eq_we       (eqWe),
        .lt_we       (ltWe),
        .branch_en   (branchEn),
        .branch_cond (branchCond),
        .target_idx  (targetIdx),
        .lut_we      (lutWe),
        .lut_addr    (lutAddr),
        .lut_data    (lutData),
        .PC          (pc),
        .eq_q        (eqQ),
        .lt_q        (ltQ),
        .taken       (taken),
        .done        (done)
`ifdef PC_BRANCH_COUNT_EN
        ,
        .taken_cnt   (takenCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       reset;
        bit       start;
        bit       halt;
        bit       stall;
        bit       eqF;
        bit       ltF;
        bit       eqWe;
        bit       ltWe;
        bit       brEn;
        bit [1:0] cond;
        int       idx;
        bit       lutWe;
        int       lutAddr;
        int       lutData;
    } stim_t;

    typedef struct {
        int pc;
        bit eq;
        bit lt;
        bit taken;
        bit done;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    // Behavioural model: running/halted flags, PC as an integer, LUT as an int array
    bit mRun   = 1'b0;
    bit mDone  = 1'b0;
    bit mEq    = 1'b0;
    bit mLt    = 1'b0;
    bit mTaken = 1'b0;
    int mPc    = START_PC;
    int mLut[LUT_DEPTH];

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic bit condMet(input bit [1:0] c);
        case (c)
            2'd0:    return 1'b1;
            2'd1:    return mEq;
            2'd2:    return mLt;
            default: return !mEq;
        endcase
    endfunction

    task automatic modelStep(input stim_t s);
        bit goBranch;
        int target;
        if (s.reset) begin
            mRun = 0; mDone = 0; mEq = 0; mLt = 0; mTaken = 0; mPc = START_PC;
            foreach (mLut[i]) mLut[i] = 0;
            return;
        end
        goBranch = s.brEn && condMet(s.cond);
        target   = mLut[s.idx];
        mTaken   = 0;
        if (!mRun) begin
            if (s.start) begin
                mRun = 1; mDone = 0; mEq = 0; mLt = 0; mPc = START_PC;
            end
        end else if (!s.stall) begin
            if (s.halt) begin
                mRun = 0; mDone = 1;
            end else if (goBranch) begin
                mPc = target; mTaken = 1;
            end else begin
                mPc = (mPc + 1) % PC_MOD;
            end
            if (s.eqWe) mEq = s.eqF;
            if (s.ltWe) mLt = s.ltF;
        end
        if (s.lutWe) mLut[s.lutAddr] = s.lutData;
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst          = s.reset;
        start        = s.start;
        haltReq      = s.halt;
        stall        = s.stall;
        equalFlag    = s.eqF;
        lessThanFlag = s.ltF;
        eqWe         = s.eqWe;
        ltWe         = s.ltWe;
        branchEn     = s.brEn;
        branchCond   = s.cond;
        targetIdx    = LUT_AW'(s.idx);
        lutWe        = s.lutWe;
        lutAddr      = LUT_AW'(s.lutAddr);
        lutData      = PC_W'(s.lutData);
        modelStep(s);
        e.pc = mPc; e.eq = mEq; e.lt = mLt; e.taken = mTaken; e.done = mDone;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checkCount++;
        if (int'(pc) === e.pc && eqQ === e.eq && ltQ === e.lt && taken === e.taken && done === e.done) begin
            passCount++;
        end else begin
            $display("[TB] FAIL outputs @%0t: got pc=%0d eq=%0b lt=%0b taken=%0b done=%0b, expected pc=%0d eq=%0b lt=%0b taken=%0b done=%0b",
                     $time, pc, eqQ, ltQ, taken, done, e.pc, e.eq, e.lt, e.taken, e.done);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) applyStimulus(idleStim());
    endtask

    task automatic runUntilPc(input int target, input int budget);
        int cycles;
        cycles = 0;
        while (mPc != target && cycles < budget) begin
            applyStimulus(idleStim());
            cycles++;
        end
        if (mPc != target) begin
            checkCount++;
            $display("[TB] FAIL runUntilPc: model pc=%0d, required %0d within %0d cycles", mPc, target, budget);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        stim_t s;

        s = idleStim(); s.reset = 1; applyStimulus(s);
        nop(2);
        s = idleStim(); s.start = 1; applyStimulus(s);
        nop(3);

        s = idleStim(); s.lutWe = 1; s.lutAddr = 3; s.lutData = 40; applyStimulus(s);
        runUntilPc(5, 20);
        s = idleStim(); s.eqWe = 1; s.eqF = 1; applyStimulus(s);
        s = idleStim(); s.brEn = 1; s.cond = 2'b01; s.idx = 3; applyStimulus(s);
        nop(2);

        s = idleStim(); s.halt = 1; applyStimulus(s);
        s = idleStim(); s.start = 1; applyStimulus(s);
        s = idleStim(); s.eqWe = 1; s.eqF = 1; s.brEn = 1; s.cond = 2'b01; s.idx = 3; applyStimulus(s);
        s = idleStim(); s.brEn = 1; s.cond = 2'b01; s.idx = 3; applyStimulus(s);
        s = idleStim(); s.halt = 1; applyStimulus(s);
        s = idleStim(); s.start = 1; applyStimulus(s);

        runUntilPc(9, 20);
        for (int i = 0; i < 3; i++) begin
            s = idleStim(); s.stall = 1; s.brEn = 1; s.cond = 2'b00; s.idx = 3;
            s.eqWe = 1; s.eqF = 1; s.halt = 1; applyStimulus(s);
        end
        nop(1);

        runUntilPc(12, 20);
        s = idleStim(); s.halt = 1; s.brEn = 1; applyStimulus(s);
        s = idleStim(); s.brEn = 1; s.eqWe = 1; s.eqF = 1; applyStimulus(s);
        nop(1);
        s = idleStim(); s.start = 1; applyStimulus(s);
        nop(3);
        s = idleStim(); s.reset = 1; applyStimulus(s);
        s = idleStim(); s.halt = 1; applyStimulus(s);
        nop(1);

        s = idleStim(); s.start = 1; s.lutWe = 1; s.lutAddr = 5; s.lutData = 1021; applyStimulus(s);
        s = idleStim(); s.brEn = 1; s.cond = 2'b00; s.idx = 5; applyStimulus(s);
        nop(4);

        s = idleStim(); s.lutWe = 1; s.lutAddr = 7; s.lutData = 100; applyStimulus(s);
        s = idleStim(); s.brEn = 1; s.idx = 7; s.lutWe = 1; s.lutAddr = 7; s.lutData = 200; applyStimulus(s);
        s = idleStim(); s.brEn = 1; s.idx = 7; applyStimulus(s);
        s = idleStim(); s.ltWe = 1; s.ltF = 1; applyStimulus(s);
        s = idleStim(); s.brEn = 1; s.cond = 2'b10; s.idx = 3; applyStimulus(s);
        s = idleStim(); s.brEn = 1; s.cond = 2'b11; s.idx = 5; applyStimulus(s);
        nop(1);

        for (int i = 0; i < 3000; i++) begin
            s = idleStim();
            s.reset   = ($urandom_range(0, 299) == 0);
            s.start   = ($urandom_range(0, 15) == 0);
            s.halt    = ($urandom_range(0, 29) == 0);
            s.stall   = ($urandom_range(0, 7) == 0);
            s.eqF     = $urandom_range(0, 1);
            s.ltF     = $urandom_range(0, 1);
            s.eqWe    = ($urandom_range(0, 2) == 0);
            s.ltWe    = ($urandom_range(0, 2) == 0);
            s.brEn    = ($urandom_range(0, 2) == 0);
            s.cond    = 2'($urandom_range(0, 3));
            s.idx     = $urandom_range(0, LUT_DEPTH - 1);
            s.lutWe   = ($urandom_range(0, 3) == 0);
            s.lutAddr = $urandom_range(0, LUT_DEPTH - 1);
            s.lutData = $urandom_range(0, PC_MOD - 1);
            applyStimulus(s);
        end

        repeat (3) @(negedge clk);
        checkCount++;
        if (expQ.size() == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL scoreboard drain: %0d entries left, required 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
